dtw_bt_walker: RTL and testbench
================================

// Module: dtw_bt_walker
// PURPOSE
//  Parametrised backtrace unit for the DTW systolic array. Captures each PE's 2-bit path decision into a path memory.
//  On start it walks back from cell (T-1,R-1) to (0,0), emitting one packed word per visited cell towards SRAM.
//  Output uses a valid/ready handshake. Sits between the last PE (drives bt_start) and the SRAM write port.
// PARAMETERS
//  N_PE      6   PEs reporting per capture beat
//  IDX_W     5   bits per t/r index; MAX_LEN = 2**IDX_W
//  SCORE_W   16  final-score width
//  FIELD_W   8   output index field width (>= IDX_W, zero-extended)
// PORTS
//  clk           in   1             clock
//  nrst          in   1             synchronous active-low reset
//  i_cap_valid   in   1             capture beat valid
//  i_cell_valid  in   N_PE          per-PE write mask, PE k = bit k
//  i_tindex      in   N_PE*IDX_W    PE k t-index at [k*IDX_W +: IDX_W]
//  i_rindex      in   N_PE*IDX_W    PE k r-index, same packing
//  i_path        in   N_PE*2        PE k path code at [2k +: 2]
//  i_score_valid in   1             final score valid
//  i_score       in   SCORE_W       final DTW score D(T-1,R-1)
//  i_t_len       in   IDX_W+1       test length, sampled at start
//  i_r_len       in   IDX_W+1       reference length, sampled at start
//  i_bt_start    in   1             one-cycle start pulse
//  o_valid       out  1             o_data valid
//  i_ready       in   1             SRAM side accepts o_data
//  o_data        out  2*FIELD_W+SCORE_W  {t, r, score_or_0}
//  o_busy        out  1             walk in progress
//  o_bt_end      out  1             one-cycle done pulse
//  o_err         out  1             sticky error, cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, score register 0. Path memory is not cleared; contents undefined.
//  Path code: 00 diag (t-1,r-1); 01 up (t-1,r); 10 left (t,r-1); 11 illegal.
//  IDLE:
//   - Capture: each cycle with i_cap_valid, for every k with i_cell_valid[k], mem[t_k][r_k] <= path_k. Write takes effect next cycle.
//   - Score: i_score_valid latches i_score.
//   - Start: i_bt_start latches both lengths.
//     If either length is 0 or > MAX_LEN: set o_err, pulse o_bt_end next cycle, emit no words.
//     Otherwise go to WALK at (t_len-1, r_len-1).
//  WALK:
//   - Output: o_valid=1 from the cycle after start. o_data = {t, r, score} for the first word, {t, r, 0} for later words.
//   - Hold: o_data and o_valid stay stable while i_ready=0.
//   - Step on o_valid & i_ready, using the stored code at the current cell:
//     t==0 forces left; r==0 forces up; both forced rules override the stored code.
//     Illegal code 11 (not forced): set o_err, go to DONE.
//   - Termination: after (0,0) is accepted, go to DONE. Word count <= t_len+r_len-1.
//  DONE: o_bt_end=1 for one cycle, then IDLE.
//  Busy: o_busy=1 in WALK and DONE (and TRAIL when the trailer option is compiled in).
//  While busy: i_bt_start is ignored. i_cap_valid with any mask bit set drops the write and sets o_err. Score updates are ignored.
//  Simultaneous events in IDLE: capture write and start in the same cycle means the write lands first and the walk sees it.
//  Reset mid-walk: next cycle IDLE, o_valid=0, no o_bt_end.
// CONFIGURATION
//  DTW_BT_STEP_TRAILER_EN defined:
//   - After (0,0) is accepted, enter TRAIL and emit one extra word {all-ones t, all-ones r, step_count}.
//   - step_count = number of cell words, zero-extended to SCORE_W. DONE follows acceptance of the trailer.
//   - Not emitted on a length error or an illegal-code abort.
//  Undefined: no TRAIL state; DONE directly after (0,0).
// STRUCTURE
//  dtw_pkg:
//   - Path-code localparams PATH_DIAG/PATH_UP/PATH_LEFT/PATH_ILL.
//   - FSM state typedef/encoding: IDLE, WALK, TRAIL, DONE.
//   - Word-pack function.
//  Sub-module dtw_path_mem:
//   - MAX_LEN x MAX_LEN x 2-bit register array.
//   - N_PE write ports, one combinational read port.
//   - On same-address writes in one beat, highest PE index wins.
//  Top holds FSM, cursor (t,r), score/length registers, step counter.
// TESTING
//  T1 2x2, all diag, score 0x0123, ready=1 -> words (1,1,0x0123),(0,0,0); o_bt_end pulse 1 cycle later.
//  T2 t_len=3, r_len=1, mem garbage -> (2,0,S),(1,0,0),(0,0,0) via forced up; o_err=0.
//  T3 4x4 mixed path, i_ready low 3 cycles mid-walk -> o_data stable, no skipped/duplicated cells vs golden model.
//  T4 code 11 at (2,2) of 3x3 -> word (2,2,S) then o_err=1, o_bt_end, no further words.
//  T5 nrst low during 3rd word -> o_valid=0 next cycle, IDLE, no o_bt_end; restart yields full correct walk.
//  T6 trailer option compiled in, 2x3 all diag -> trailer {FF,FF,step_count} after (0,0), step_count=3; walk words (1,2,S),(0,1,0),(0,0,0).

Source files
------------

// File: rtl/dtw_pkg.sv
// dtw_pkg: shared path codes, walker FSM states and the output word packer.
//  PATH_DIAG/PATH_UP/PATH_LEFT/PATH_ILL : 2-bit path decision codes
//  state_t                              : IDLE, WALK, TRAIL, DONE
//  pack_word(t, r, s, fw, sw)           : {t, r, s} with r/s field widths fw/sw
package dtw_pkg;
   localparam logic [1:0] PATH_DIAG = 2'b00;
   localparam logic [1:0] PATH_UP   = 2'b01;
   localparam logic [1:0] PATH_LEFT = 2'b10;
   localparam logic [1:0] PATH_ILL  = 2'b11;
   localparam int PK_W = 128;
   typedef enum logic [1:0] {S_IDLE, S_WALK, S_TRAIL, S_DONE} state_t;
   // Fields arrive zero-extended to PK_W; the caller truncates to its word width.
   function automatic logic [PK_W-1:0] pack_word(input logic [PK_W-1:0] t, input logic [PK_W-1:0] r,
                                                 input logic [PK_W-1:0] s, input int fw, input int sw);
      return (t << (fw + sw)) | (r << sw) | s;
   endfunction
endpackage

// File: rtl/dtw_path_mem.sv
// dtw_path_mem: MAX_LEN x MAX_LEN array of 2-bit path codes, N_PE write ports, one async read port.
//  clk      in  clock
//  i_we     in  write beat enable
//  i_mask   in  per-port write mask, port k = bit k
//  i_tindex in  port k t-index at [k*IDX_W +: IDX_W]
//  i_rindex in  port k r-index, same packing
//  i_path   in  port k code at [2k +: 2]
//  i_t/i_r  in  read address
//  o_code   out code stored at (i_t, i_r)
module dtw_path_mem #(
   parameter int N_PE  = 6,
   parameter int IDX_W = 5
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [N_PE-1:0]       i_mask,
   input  logic [N_PE*IDX_W-1:0] i_tindex,
   input  logic [N_PE*IDX_W-1:0] i_rindex,
   input  logic [N_PE*2-1:0]     i_path,
   input  logic [IDX_W-1:0]      i_t,
   input  logic [IDX_W-1:0]      i_r,
   output logic [1:0]            o_code
);
   localparam int MAX_LEN = 2**IDX_W;
   logic [1:0] r_mem [MAX_LEN][MAX_LEN];
   // No reset: contents are only meaningful once written. Later ports override
   // earlier ones, so the highest PE index wins on an address collision.
   always_ff @(posedge clk)
      if (i_we)
         for (int k = 0; k < N_PE; k++)
            if (i_mask[k])
               r_mem[i_tindex[k*IDX_W +: IDX_W]][i_rindex[k*IDX_W +: IDX_W]] <= i_path[2*k +: 2];
   assign o_code = r_mem[i_t][i_r];
endmodule

// File: rtl/dtw_bt_walker.sv
// dtw_bt_walker: DTW backtrace unit; captures PE path codes and walks (T-1,R-1)->(0,0) emitting words.
//  clk, nrst (sync, active low)
//  i_cap_valid/i_cell_valid/i_tindex/i_rindex/i_path : path capture beat (idle only)
//  i_score_valid/i_score                             : final score latch (idle only)
//  i_t_len/i_r_len/i_bt_start                        : walk start with lengths
//  o_valid/i_ready/o_data                            : output word {t, r, score_or_0}
//  o_busy, o_bt_end, o_err                           : status
//  Option DTW_BT_STEP_TRAILER_EN: append {ones, ones, step_count} after (0,0).
module dtw_bt_walker
   import dtw_pkg::*;
#(
   parameter int N_PE    = 6,
   parameter int IDX_W   = 5,
   parameter int SCORE_W = 16,
   parameter int FIELD_W = 8
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          i_cap_valid,
   input  logic [N_PE-1:0]               i_cell_valid,
   input  logic [N_PE*IDX_W-1:0]         i_tindex,
   input  logic [N_PE*IDX_W-1:0]         i_rindex,
   input  logic [N_PE*2-1:0]             i_path,
   input  logic                          i_score_valid,
   input  logic [SCORE_W-1:0]            i_score,
   input  logic [IDX_W:0]                i_t_len,
   input  logic [IDX_W:0]                i_r_len,
   input  logic                          i_bt_start,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [2*FIELD_W+SCORE_W-1:0]  o_data,
   output logic                          o_busy,
   output logic                          o_bt_end,
   output logic                          o_err
);
   localparam int OUT_W = 2*FIELD_W + SCORE_W;
   localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(2**IDX_W);
`ifdef DTW_BT_STEP_TRAILER_EN
   localparam state_t S_LAST = S_TRAIL;
`else
   localparam state_t S_LAST = S_DONE;
`endif
   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_t, r_r;
   logic [SCORE_W-1:0] r_score;
   logic               r_first, r_err;
   logic [1:0]         w_code, w_dir;
   logic               w_idle, w_fire, w_last, w_len_bad;
`ifdef DTW_BT_STEP_TRAILER_EN
   logic [IDX_W:0]     r_steps;
`endif
   dtw_path_mem #(.N_PE(N_PE), .IDX_W(IDX_W)) u_mem (
      .clk      (clk),
      .i_we     (w_idle & i_cap_valid),
      .i_mask   (i_cell_valid),
      .i_tindex (i_tindex),
      .i_rindex (i_rindex),
      .i_path   (i_path),
      .i_t      (r_t),
      .i_r      (r_r),
      .o_code   (w_code)
   );
   assign w_idle    = r_state == S_IDLE;
   assign o_valid   = r_state == S_WALK || r_state == S_TRAIL;
   assign w_fire    = o_valid & i_ready;
   assign w_last    = r_t == '0 && r_r == '0;
   assign w_len_bad = i_t_len == '0 || i_r_len == '0 || i_t_len > MAX_LEN || i_r_len > MAX_LEN;
   // Edge rows override the stored code so the walk can never leave the grid.
   assign w_dir     = r_t == '0 ? PATH_LEFT : r_r == '0 ? PATH_UP : w_code;
   assign o_busy    = !w_idle;
   assign o_bt_end  = r_state == S_DONE;
   assign o_err     = r_err;
   always_ff @(posedge clk)
      r_state <= !nrst ? S_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      o_data = '0;
      case (r_state)
         S_IDLE: w_next = i_bt_start ? (w_len_bad ? S_DONE : S_WALK) : S_IDLE;
         S_WALK: begin
            o_data = OUT_W'(pack_word(PK_W'(r_t), PK_W'(r_r), PK_W'(r_first ? r_score : '0), FIELD_W, SCORE_W));
            w_next = !w_fire ? S_WALK : w_last ? S_LAST : w_dir == PATH_ILL ? S_DONE : S_WALK;
         end
`ifdef DTW_BT_STEP_TRAILER_EN
         S_TRAIL: begin
            o_data = OUT_W'(pack_word(PK_W'({FIELD_W{1'b1}}), PK_W'({FIELD_W{1'b1}}), PK_W'(r_steps), FIELD_W, SCORE_W));
            w_next = w_fire ? S_DONE : S_TRAIL;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_t     <= '0;
         r_r     <= '0;
         r_score <= '0;
         r_first <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_idle && i_score_valid)
            r_score <= i_score;
         if (w_idle && i_bt_start) begin
            r_t     <= IDX_W'(i_t_len - (IDX_W+1)'(1));
            r_r     <= IDX_W'(i_r_len - (IDX_W+1)'(1));
            r_first <= 1'b1;
            r_err   <= w_len_bad;
         end else if ((!w_idle && i_cap_valid && |i_cell_valid) ||
                      (r_state == S_WALK && w_fire && w_dir == PATH_ILL))
            r_err <= 1'b1;
         if (r_state == S_WALK && w_fire) begin
            r_first <= 1'b0;
            r_t     <= (w_dir == PATH_DIAG || w_dir == PATH_UP)   ? r_t - IDX_W'(1) : r_t;
            r_r     <= (w_dir == PATH_DIAG || w_dir == PATH_LEFT) ? r_r - IDX_W'(1) : r_r;
         end
      end
   end
`ifdef DTW_BT_STEP_TRAILER_EN
   always_ff @(posedge clk)
      if (!nrst || (w_idle && i_bt_start))
         r_steps <= '0;
      else if (r_state == S_WALK && w_fire)
         r_steps <= r_steps + (IDX_W+1)'(1);
`endif
endmodule

// File: tb/tb_dtw_bt_walker.sv
// tb_dtw_bt_walker: randomized scoreboard bench for dtw_bt_walker against a grid-walk reference model.
module tb_dtw_bt_walker;
   localparam int N_PE = 6, IDX_W = 5, SCORE_W = 16, FIELD_W = 8, MAX_LEN = 32, OUT_W = 32;
   logic                 clk = 0, nrst = 0;
   logic                 i_cap_valid = 0, i_score_valid = 0, i_bt_start = 0, i_ready = 1;
   logic [N_PE-1:0]      i_cell_valid = '0;
   logic [N_PE*IDX_W-1:0] i_tindex = '0, i_rindex = '0;
   logic [N_PE*2-1:0]    i_path = '0;
   logic [SCORE_W-1:0]   i_score = '0;
   logic [IDX_W:0]       i_t_len = '0, i_r_len = '0;
   logic                 o_valid, o_busy, o_bt_end, o_err;
   logic [OUT_W-1:0]     o_data;
   logic [1:0]           ref_mem [MAX_LEN][MAX_LEN];
   logic [OUT_W-1:0]     exp_q [$];
   logic [SCORE_W-1:0]   m_score = '0;
   logic                 stall = 0;
   logic [OUT_W-1:0]     held = '0;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   dtw_bt_walker #(.N_PE(N_PE), .IDX_W(IDX_W), .SCORE_W(SCORE_W), .FIELD_W(FIELD_W)) dut (
      .clk(clk), .nrst(nrst), .i_cap_valid(i_cap_valid), .i_cell_valid(i_cell_valid),
      .i_tindex(i_tindex), .i_rindex(i_rindex), .i_path(i_path), .i_score_valid(i_score_valid),
      .i_score(i_score), .i_t_len(i_t_len), .i_r_len(i_r_len), .i_bt_start(i_bt_start),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy),
      .o_bt_end(o_bt_end), .o_err(o_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks hold stability.
   always @(negedge clk) begin
      if (!nrst) stall = 0;
      else begin
         if (stall) begin
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_data", 64'(o_data), 64'(held));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word got=%0h want=none", o_data);
            end else chk("word", 64'(o_data), 64'(exp_q.pop_front()));
         end
         stall = o_valid && !i_ready;
         held  = o_data;
      end
   end

   // Reference: follow the path rules over the model grid, queueing every expected word.
   function automatic int model(input int tl, input int rl, input logic [SCORE_W-1:0] s, output bit err);
      int t = tl - 1, r = rl - 1, n = 0;
      logic [1:0] c;
      err = 0;
      if (tl < 1 || rl < 1 || tl > MAX_LEN || rl > MAX_LEN) begin
         err = 1;
         return 0;
      end
      while (1) begin
         exp_q.push_back({FIELD_W'(t), FIELD_W'(r), n == 0 ? s : SCORE_W'(0)});
         n++;
         if (t == 0 && r == 0) break;
         c = t == 0 ? 2'd2 : r == 0 ? 2'd1 : ref_mem[t][r];
         if (c == 2'd3) begin
            err = 1;
            return n;
         end
         if (c == 2'd0) begin t--; r--; end
         else if (c == 2'd1) t--;
         else r--;
      end
`ifdef DTW_BT_STEP_TRAILER_EN
      exp_q.push_back({{FIELD_W{1'b1}}, {FIELD_W{1'b1}}, SCORE_W'(n)});
      n++;
`endif
      return n;
   endfunction

   task automatic beat();
      i_cap_valid = 1;
      @(posedge clk); #1;
      i_cap_valid = 0;
      i_cell_valid = '0;
   endtask

   task automatic put_slot(input int k, input int t, input int r, input logic [1:0] c);
      i_tindex[k*IDX_W +: IDX_W] = IDX_W'(t);
      i_rindex[k*IDX_W +: IDX_W] = IDX_W'(r);
      i_path[2*k +: 2] = c;
      i_cell_valid[k] = 1;
   endtask

   // mode 0..3: fixed code, 4: random legal, 5: random with occasional illegal
   task automatic write_grid(input int tl, input int rl, input int mode);
      int k = 0;
      logic [1:0] c;
      for (int t = 0; t < tl; t++)
         for (int r = 0; r < rl; r++) begin
            c = mode < 4 ? 2'(mode) : (mode == 5 && $urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ref_mem[t][r] = c;
            put_slot(k, t, r, c);
            k++;
            if (k == N_PE) begin
               beat();
               k = 0;
            end
         end
      if (k != 0) beat();
   endtask

   task automatic set_score(input logic [SCORE_W-1:0] s);
      i_score_valid = 1;
      i_score = s;
      m_score = s;
      @(posedge clk); #1;
      i_score_valid = 0;
   endtask

   // rmode 0: ready always high, 1: random ready, 2: ready low 3 cycles mid-walk
   task automatic run_walk(input int tl, input int rl, input int rmode, input bit inject, input bit same_cyc);
      bit err;
      int n, cnt;
      logic [1:0] c;
      if (same_cyc) begin
         ref_mem[tl-1][rl-1] = 2'd1;
         put_slot(0, tl - 1, rl - 1, 2'd1);
         i_cap_valid = 1;
      end
      n = model(tl, rl, m_score, err);
      i_bt_start = 1;
      i_t_len = (IDX_W+1)'(tl);
      i_r_len = (IDX_W+1)'(rl);
      i_ready = rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      i_bt_start = 0;
      i_cap_valid = 0;
      i_cell_valid = '0;
      cnt = 1;
      while (!o_bt_end && cnt < 400) begin
         if (inject && cnt == 1) begin
            c = ref_mem[tl-1][rl-1] == 2'd0 ? 2'd1 : 2'd0;
            put_slot(2, tl - 1, rl - 1, c);
            i_cap_valid = 1;
         end else begin
            i_cap_valid = 0;
            i_cell_valid = '0;
         end
         i_ready = rmode == 0 ? 1'b1 : rmode == 2 ? !(cnt >= 2 && cnt < 5) : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cnt++;
      end
      i_cap_valid = 0;
      i_cell_valid = '0;
      chk("bt_end_seen", 64'(o_bt_end), 64'd1);
      if (rmode == 0) chk("end_cycle", 64'(cnt), 64'(n + 1));
      chk("err", 64'(o_err), 64'(err | inject));
      chk("words_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      i_ready = 1;
      @(posedge clk); #1;
      chk("end_pulse", 64'(o_bt_end), 64'd0);
      chk("idle", 64'(o_busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit err;
      int n, tl, rl;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_end", 64'(o_bt_end), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      chk("rst_data", 64'(o_data), 64'd0);
      nrst = 1;
      @(posedge clk); #1;
      // 2x2 all diagonal
      write_grid(2, 2, 0);
      set_score(16'h0123);
      run_walk(2, 2, 0, 0, 0);
      // single reference column: walk is forced upward regardless of memory
      set_score(16'hBEEF);
      run_walk(3, 1, 0, 0, 0);
      // mixed 4x4 with a ready stall mid-walk
      write_grid(4, 4, 4);
      set_score(16'($urandom));
      run_walk(4, 4, 2, 0, 0);
      // illegal code at the start cell
      write_grid(3, 3, 0);
      put_slot(0, 2, 2, 2'd3);
      ref_mem[2][2] = 2'd3;
      beat();
      set_score(16'h5A5A);
      run_walk(3, 3, 0, 0, 0);
      // length errors, then a clean start clears the sticky error
      run_walk(0, 3, 0, 0, 0);
      run_walk(33, 2, 0, 0, 0);
      run_walk(4, 0, 0, 0, 0);
      run_walk(63, 63, 0, 0, 0);
      write_grid(2, 3, 0);
      run_walk(2, 3, 0, 0, 0);
      // same-address collision in one beat: highest PE wins
      write_grid(2, 2, 0);
      put_slot(0, 1, 1, 2'd0);
      put_slot(5, 1, 1, 2'd1);
      ref_mem[1][1] = 2'd1;
      beat();
      run_walk(2, 2, 0, 0, 0);
      // capture while busy is dropped and flags an error
      write_grid(5, 5, 4);
      run_walk(5, 5, 0, 1, 0);
      run_walk(5, 5, 1, 0, 0);
      // reset during the third word
      write_grid(4, 4, 4);
      set_score(16'h7777);
      n = model(4, 4, m_score, err);
      i_bt_start = 1;
      i_t_len = 4;
      i_r_len = 4;
      i_ready = 1;
      @(posedge clk); #1;
      i_bt_start = 0;
      repeat (2) begin @(posedge clk); #1; end
      nrst = 0;
      @(posedge clk); #1;
      chk("rstw_valid", 64'(o_valid), 64'd0);
      chk("rstw_busy", 64'(o_busy), 64'd0);
      chk("rstw_end", 64'(o_bt_end), 64'd0);
      chk("rstw_left", 64'(exp_q.size()), 64'(n - 2));
      exp_q.delete();
      m_score = '0;
      nrst = 1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rstw_no_end", 64'(o_bt_end), 64'd0);
      end
      run_walk(4, 4, 1, 0, 0);
      // full-size grid
      write_grid(32, 32, 4);
      set_score(16'hFFFF);
      run_walk(32, 32, 0, 0, 0);
      // random grids, ready patterns and same-cycle capture+start
      repeat (25) begin
         tl = $urandom_range(1, 10);
         rl = $urandom_range(1, 10);
         write_grid(tl, rl, 5);
         if ($urandom_range(0, 1) == 1) set_score(16'($urandom));
         run_walk(tl, rl, $urandom_range(0, 1), 0, 1'($urandom_range(0, 1)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
